// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t        : 32-bit machine word
//   fetch_state_t : fetch-stage control states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage, producer side of the IF/ID latch.
// Owns the PC, issues word reads to instruction memory and presents each
// fetched word with its next-PC under a valid/stall handshake. Redirects
// and halt from later stages are absorbed without delivering wrong-path
// instructions.
//   CLK, RST             : clock, async active-high reset
//   ihit, imemload       : memory response for imemaddr (same cycle)
//   imemREN, imemaddr    : memory read request
//   stall                : downstream latch will not capture this cycle
//   redirect, redirect_pc: control transfer target (low 2 bits dropped)
//   halt                 : stop fetching until reset
//   valid_out, npc_out, instr_out : delivered instruction (combinational)
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        valid_out,
  output logic [31:0] npc_out,
  output logic [31:0] instr_out
);

  fetch_state_t fstate_q, fstate_d;
  word_t        pc_q, pc_d;
  word_t        pending_pc_q, pending_pc_d;
  word_t        ibuf_q, ibuf_d;

  word_t rpc;
  word_t pc_inc;
  logic  ren;
  logic  vld;
  word_t instr;

  assign rpc    = {redirect_pc[31:2], 2'b00};
  assign pc_inc = pc_q + PC_STEP;  // modulo 2^32, wrap is intentional

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fstate_q     <= FETCH;
      pc_q         <= PC_INIT;
      pending_pc_q <= '0;
      ibuf_q       <= '0;
    end else begin
      fstate_q     <= fstate_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      ibuf_q       <= ibuf_d;
    end
  end

  always_comb begin
    fstate_d     = fstate_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    ibuf_d       = ibuf_q;
    ren          = 1'b0;
    vld          = 1'b0;
    instr        = '0;

    case (fstate_q)
      FETCH: begin
        ren = 1'b1;
        if (ihit && !redirect) begin
          vld   = 1'b1;
          instr = imemload;
        end
        if (redirect) begin
          if (ihit) begin
            pc_d = rpc;
          end else begin
            // Request at pc is still in flight; imemaddr must stay on it
            // until the memory answers, so park the target.
            pending_pc_d = rpc;
            fstate_d     = DISCARD;
          end
        end else if (ihit) begin
          if (stall) begin
            ibuf_d   = imemload;
            fstate_d = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      HOLD: begin
        vld   = !redirect;
        instr = ibuf_q;
        if (redirect) begin
          pc_d     = rpc;
          fstate_d = FETCH;
        end else if (!stall) begin
          pc_d     = pc_inc;
          fstate_d = FETCH;
        end
      end

      DISCARD: begin
        ren = 1'b1;
        if (ihit) begin
          pc_d     = redirect ? rpc : pending_pc_q;
          fstate_d = FETCH;
        end else if (redirect) begin
          pending_pc_d = rpc;
        end
      end

      default: ;  // HALTED: nothing moves until reset
    endcase

    // Halt overrides everything and drops any outstanding request.
    if (halt) fstate_d = HALTED;
  end

  // Reset gates the request and delivery combinationally so nothing
  // leaks out while RST is held.
  assign imemREN   = ren && !RST;
  assign imemaddr  = pc_q;
  assign valid_out = vld && !RST;
  assign npc_out   = valid_out ? pc_inc : '0;
  assign instr_out = valid_out ? instr  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        valid_out;
  logic [31:0] npc_out;
  logic [31:0] instr_out;

  int nchk = 0;
  int nerr = 0;

  fetch_unit #(.PC_INIT(32'h0000_0040)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .valid_out(valid_out), .npc_out(npc_out), .instr_out(instr_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inputs change on the falling edge, outputs checked 1ns later
  task automatic nxt();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    nxt();
    chk("rst_ren",   {31'd0, imemREN},   32'd0);
    chk("rst_addr",  imemaddr,           32'h40);
    chk("rst_vld",   {31'd0, valid_out}, 32'd0);
    chk("rst_npc",   npc_out,            32'd0);
    chk("rst_instr", instr_out,          32'd0);

    // zero-wait streaming from PC_INIT
    RST = 1'b0; ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imemload = 32'hA000_0000 + i;
      #1;
      chk("strm_addr",  imemaddr,           32'h40 + 4*i);
      chk("strm_npc",   npc_out,            32'h44 + 4*i);
      chk("strm_vld",   {31'd0, valid_out}, 32'd1);
      chk("strm_instr", instr_out,          32'hA000_0000 + i);
      nxt();
    end

    // redirect with ihit: data dropped, pc -> 0x100
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("rdh_vld", {31'd0, valid_out}, 32'd0);
    nxt();
    redirect = 1'b0;
    chk("rdh_addr", imemaddr, 32'h100);

    // hit at 0x100 with stall, then 3 stalled HOLD cycles
    stall = 1'b1; imemload = 32'hCAFE_0100; #1;
    chk("st_vld",   {31'd0, valid_out}, 32'd1);
    chk("st_instr", instr_out,          32'hCAFE_0100);
    nxt();
    imemload = 32'hDEAD_DEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ren",   {31'd0, imemREN},   32'd0);
      chk("hold_vld",   {31'd0, valid_out}, 32'd1);
      chk("hold_instr", instr_out,          32'hCAFE_0100);
      chk("hold_npc",   npc_out,            32'h104);
      if (i < 2) nxt();
    end
    stall = 1'b0;
    nxt();
    chk("unst_addr", imemaddr, 32'h104);

    // enter HOLD again, then redirect + stall together
    stall = 1'b1; imemload = 32'h1111_2222;
    nxt();
    redirect = 1'b1; redirect_pc = 32'h303; #1;
    chk("hrd_vld", {31'd0, valid_out}, 32'd0);
    nxt();
    redirect = 1'b0; stall = 1'b0;
    chk("hrd_addr", imemaddr, 32'h300);

    // move pc to 0x10, then redirect to 0x200 with request pending
    redirect = 1'b1; redirect_pc = 32'h10;
    nxt();
    ihit = 1'b0; redirect_pc = 32'h200; #1;
    chk("dis0_addr", imemaddr,           32'h10);
    chk("dis0_vld",  {31'd0, valid_out}, 32'd0);
    nxt();
    redirect = 1'b0; #1;
    chk("dis1_addr", imemaddr,           32'h10);
    chk("dis1_ren",  {31'd0, imemREN},   32'd1);
    chk("dis1_vld",  {31'd0, valid_out}, 32'd0);
    nxt();
    ihit = 1'b1; imemload = 32'h5555_AAAA; #1;
    chk("dis2_addr", imemaddr,           32'h10);
    chk("dis2_vld",  {31'd0, valid_out}, 32'd0);
    nxt();
    chk("dis_tgt",  imemaddr,           32'h200);
    chk("dis_tvld", {31'd0, valid_out}, 32'd1);
    chk("dis_tnpc", npc_out,            32'h204);

    // pc wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect = 1'b0; #1;
    chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    chk("wrap_npc",  npc_out,  32'h0);
    nxt();
    chk("wrap_next", imemaddr, 32'h0);

    // halt with a request outstanding
    ihit = 1'b0; halt = 1'b1; #1;
    chk("hlt0_ren", {31'd0, imemREN}, 32'd1);
    nxt();
    halt = 1'b0; ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h800;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hlt_ren", {31'd0, imemREN},   32'd0);
      chk("hlt_vld", {31'd0, valid_out}, 32'd0);
      nxt();
    end
    redirect = 1'b0;

    // reset pulse restarts at PC_INIT
    RST = 1'b1; #1;
    chk("rst2_addr", imemaddr, 32'h40);
    chk("rst2_vld",  {31'd0, valid_out}, 32'd0);
    nxt();
    RST = 1'b0; imemload = 32'h7777_0040; #1;
    chk("rst2_ren",  {31'd0, imemREN},   32'd1);
    chk("rst2_rvld", {31'd0, valid_out}, 32'd1);
    chk("rst2_npc",  npc_out,            32'h44);
    nxt();
    chk("rst2_next", imemaddr, 32'h44);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU and the producer side of the IF/ID latch. Owns the PC and issues word reads to instruction memory, holding each request until `ihit`. Presents each fetched instruction with its next-PC under a valid/stall handshake, and absorbs redirects (branch, jump) and halt from later stages without ever delivering a wrong-path instruction.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `ihit`  in  1  instruction memory returns `imemload` for `imemaddr` this cycle.
- `imemload`  in  32  instruction data, valid only with `ihit`.
- `imemREN`  out  1  read request to instruction memory.
- `imemaddr`  out  32  word address of the request.
- `stall`  in  1  IF/ID latch will not capture this cycle.
- `redirect`  in  1  control transfer resolved downstream; flush fetch.
- `redirect_pc`  in  32  target of `redirect`; bits [1:0] ignored and forced to 0.
- `halt`  in  1  halt asserted downstream; fetch stops permanently until reset.
- `valid_out`  out  1  `npc_out` and `instr_out` hold a deliverable instruction.
- `npc_out`  out  32  PC+4 of the delivered instruction.
- `instr_out`  out  32  delivered instruction word.

## Operation
- State register `fstate`: FETCH, HOLD, DISCARD, HALTED. Registers: `pc`, `pending_pc`, `ibuf`.
- An instruction is consumed on any edge where `valid_out && !stall`.
- FETCH: `imemREN`=1, `imemaddr`=`pc`.
  - `ihit && !redirect`: `valid_out`=1, `instr_out`=`imemload`, `npc_out`=`pc`+4.
    - `!stall`: `pc`<=`pc`+4; stay in FETCH.
    - `stall`: `ibuf`<=`imemload`; go to HOLD.
  - `ihit && redirect`: data dropped, `valid_out`=0, `pc`<=`redirect_pc`; stay in FETCH.
  - `!ihit && redirect`: `pending_pc`<=`redirect_pc`; go to DISCARD. `imemaddr` must stay stable until `ihit`.
- HOLD: `imemREN`=0, `valid_out`=1, `instr_out`=`ibuf`, `npc_out`=`pc`+4.
  - `redirect`: `valid_out` forced 0, `pc`<=`redirect_pc`; go to FETCH.
  - `!stall`: `pc`<=`pc`+4; go to FETCH.
- DISCARD: `imemREN`=1, `imemaddr`=`pc`, `valid_out`=0.
  - A further `redirect` overwrites `pending_pc`.
  - `ihit`: `pc`<=`pending_pc`, or `redirect_pc` if `redirect` is also high; go to FETCH.
- HALTED: `imemREN`=0, `valid_out`=0. All inputs are ignored; the only exit is `RST`.
- Priority in every state: `halt` > `redirect` > `stall`. `halt` takes effect from any state on the next edge and abandons any outstanding request.
- Arithmetic: `pc`+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No carry or flag is produced.

## Timing
- While `RST` is high: `fstate`=FETCH, `pc`=`PC_INIT`, `pending_pc`=0, `ibuf`=0.
- During reset `imemREN`=0, `imemaddr`=`PC_INIT`, `valid_out`=0, `npc_out`=0, `instr_out`=0.
- Reset asserted mid-operation discards every request and buffered word immediately.
- Outputs are combinational from state, `pc`, `ibuf` and the same-cycle `ihit`/`imemload`. There is no added register stage.
- Latency: the instruction is deliverable in the same cycle as `ihit`. With a zero-wait memory and no stall, throughput is one instruction per cycle.
- `redirect` is honoured in the cycle it is asserted. The first correct-path instruction appears no earlier than the `ihit` for `redirect_pc`.
- The downstream latch must capture exactly when `valid_out && !stall`. It must treat `valid_out`=0 as a bubble.

## Structure
- `cpu_types_pkg` holds `word_t` (32-bit) and the `fetch_state_t` enum (FETCH, HOLD, DISCARD, HALTED).
- Single module, no sub-module. The PC increment is inline.

## Test plan
- Reset with `PC_INIT`=32'h0000_0040, `ihit` tied to 1, no stall: after reset falls, `imemaddr` steps 0x40, 0x44, 0x48. `npc_out` is 0x44, 0x48, 0x4C, with `valid_out`=1 every cycle.
- `ihit` at `pc`=0x100 with `stall`=1 for 3 cycles: `imemREN` drops and `instr_out` holds the captured word for 3 cycles. On the first `!stall` edge, `imemaddr` becomes 0x104.
- `redirect` to 0x200 while a request at 0x10 is pending; `ihit` arrives 2 cycles later: `imemaddr` stays 0x10 until `ihit`, no `valid_out` is raised, and the next request goes to 0x200.
- `redirect` to 0x300 in HOLD together with `stall`=1: `valid_out`=0 that cycle and the next `imemaddr` is 0x300. The redirect must win over the stall.
- `halt` with a request outstanding: from the next edge `imemREN`=0 and `valid_out`=0 permanently. After a `RST` pulse, fetch resumes at `PC_INIT`.
- `pc`=32'hFFFF_FFFC with `ihit`: `npc_out`=0 and the next `imemaddr`=0.
